// File: rtl/match_sequencer_gen_if.sv
// Bus bundle between match_sequencer_gen and its neighbours: MAC/input FIFO,
// comparator bank, Avalon slave and address buffer.
// slave modport is the sequencer's view; master modport is the environment's.
interface match_sequencer_gen_if #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned HIT_W    = 64,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned SCORE_W  = 8
);
    logic                         update_done;
    logic                         ready;
    logic                         valid;
    logic                         eop;
    logic                         error;
    logic                         rdempty;
    logic [NUM_CH-1:0]            match;
    logic [NUM_CH*WEIGHT_W-1:0]   weights;
    logic [SCORE_W-1:0]           threshold;
    logic                         hit_clr;
    logic                         rdreq;
    logic                         inc_addr;
    logic                         addr;
    logic                         clear;
    logic                         pkt_match;
    logic                         pend_ovf;
    logic [NUM_CH*HIT_W-1:0]      hits;
    logic [HIT_W-1:0]             err_pkts;

    modport slave (
        input  update_done, ready, valid, eop, error, rdempty, match, weights, threshold,
               hit_clr,
        output rdreq, inc_addr, addr, clear, pkt_match, pend_ovf, hits, err_pkts
    );

    modport master (
        output update_done, ready, valid, eop, error, rdempty, match, weights, threshold,
               hit_clr,
        input  rdreq, inc_addr, addr, clear, pkt_match, pend_ovf, hits, err_pkts
    );
endinterface

// File: rtl/match_sequencer_gen.sv
// Packet match sequencer: comparator-register load, input-FIFO drain, comparator
// latency wait, weighted match scoring and memory-commit address increments.
// Keeps saturating per-channel hit counters and a saturating pending-EOP counter.
// Optional error-packet counter enabled by defining MATCH_SEQ_ERR_CNT_EN;
// otherwise err_pkts is tied to 0.
module match_sequencer_gen #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned HIT_W    = 64,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned COMP_LAT = 4,
    parameter int unsigned PEND_W   = 3
) (
    input  logic                clk,
    input  logic                n_rst,
    match_sequencer_gen_if.slave bus
);

    localparam int unsigned WAIT_W = 8;
    // Wide enough that one weight added to a saturated score cannot wrap.
    localparam int unsigned ACC_W  = SCORE_W + WEIGHT_W;

    typedef enum logic [3:0] {
        StReset,
        StLoadCompReg,
        StIdle,
        StLoadInputFifo,
        StCompare,
        StWait,
        StMatchFound,
        StLoadMemory,
        StError
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [SCORE_W-1:0]  score_q, score_d, score_sum;
    logic [ACC_W-1:0]    acc;
    logic [PEND_W-1:0]   pend_q;
    logic                pend_ovf_q;
    logic                pend_inc, pend_dec;
    logic [HIT_W-1:0]    hits_q [NUM_CH];
    logic                rdreq_q, inc_addr_q, addr_q, clear_q, pkt_match_q;

    // Saturating weighted sum of the channels currently flagging a match.
    always_comb begin
        score_sum = '0;
        acc       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.match[i]) begin
                acc = ACC_W'(score_sum) + ACC_W'(bus.weights[i*WEIGHT_W +: WEIGHT_W]);
                score_sum = (acc > ACC_W'({SCORE_W{1'b1}})) ? '1 : acc[SCORE_W-1:0];
            end
        end
    end

    // Score is captured on the last WAIT cycle so MATCH_FOUND sees a stable value.
    always_comb begin
        score_d = score_q;
        if (state_q == StWait && wait_q == '0) begin
            score_d = score_sum;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:         state_d = StLoadCompReg;
            StLoadCompReg:   if (bus.update_done) state_d = StIdle;
            StIdle:          if (bus.ready && bus.valid) state_d = StLoadInputFifo;
            StLoadInputFifo: begin
                if (pend_q != '0) begin
                    state_d = StCompare;
                end else if (bus.error) begin
                    state_d = StError;
                end
            end
            StCompare:       if (bus.rdempty) state_d = StWait;
            StWait:          if (wait_q == '0) state_d = StMatchFound;
            StMatchFound:    state_d = (score_q >= bus.threshold) ? StLoadMemory : StIdle;
            StLoadMemory:    state_d = StIdle;
            StError:         if (bus.eop) state_d = StIdle;
            default:         state_d = StReset;
        endcase
    end

    // FSM state, latency counter, score and outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= StReset;
            wait_q      <= '0;
            score_q     <= '0;
            rdreq_q     <= 1'b0;
            inc_addr_q  <= 1'b0;
            addr_q      <= 1'b0;
            clear_q     <= 1'b0;
            pkt_match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            if (state_q == StCompare) begin
                wait_q <= WAIT_W'(COMP_LAT - 1);
            end else if (state_q == StWait && wait_q != '0) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
            addr_q      <= (state_d == StLoadCompReg);
            rdreq_q     <= (state_d == StLoadInputFifo);
            clear_q     <= (state_d == StIdle) || (state_d == StMatchFound);
            pkt_match_q <= (state_d == StMatchFound) && (score_d >= bus.threshold);
            inc_addr_q  <= (state_d == StLoadMemory);
        end
    end

    // Per-channel saturating hit counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hits_q <= '{default: '0};
        end else if (bus.hit_clr) begin
            hits_q <= '{default: '0};
        end else if (state_q == StMatchFound) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.match[i] && hits_q[i] != '1) begin
                    hits_q[i] <= hits_q[i] + HIT_W'(1);
                end
            end
        end
    end

    assign pend_inc = bus.eop;
    assign pend_dec = (state_q == StMatchFound) && (pend_q != '0);

    // Pending-EOP counter: simultaneous inc/dec cancel; overflow is sticky.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pend_q     <= '0;
            pend_ovf_q <= 1'b0;
        end else if (pend_inc && !pend_dec) begin
            if (pend_q == '1) begin
                pend_ovf_q <= 1'b1;
            end else begin
                pend_q <= pend_q + PEND_W'(1);
            end
        end else if (!pend_inc && pend_dec) begin
            pend_q <= pend_q - PEND_W'(1);
        end
    end

`ifdef MATCH_SEQ_ERR_CNT_EN
    logic [HIT_W-1:0] err_q;

    // Count entries into ERROR, saturating; shares the hit-counter clear.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            err_q <= '0;
        end else if (bus.hit_clr) begin
            err_q <= '0;
        end else if (state_d == StError && state_q != StError && err_q != '1) begin
            err_q <= err_q + HIT_W'(1);
        end
    end

    assign bus.err_pkts = err_q;
`else
    assign bus.err_pkts = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_hits
        assign bus.hits[g*HIT_W +: HIT_W] = hits_q[g];
    end

    assign bus.rdreq     = rdreq_q;
    assign bus.inc_addr  = inc_addr_q;
    assign bus.addr      = addr_q;
    assign bus.clear     = clear_q;
    assign bus.pkt_match = pkt_match_q;
    assign bus.pend_ovf  = pend_ovf_q;

endmodule
